exception_ctrl: RTL and testbench
=================================

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Parameters
REQ-001 SHALL provide EXC_VECTOR, default 32'hBFC0_0380, the redirect target for all exceptions and interrupts.

Interface
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port MEM_Valid_i  in  1  MEM-stage instruction valid.
REQ-005 SHALL have port MEM_ExcFlags_i  in  8  raw flags, bit: 0 IF addr err, 1 reserved instr, 2 syscall, 3 break, 4 eret, 5 overflow, 6 store addr err, 7 load addr err.
REQ-006 SHALL have port MEM_PC_i  in  32  MEM instruction PC.
REQ-007 SHALL have port MEM_IsDelaySlot_i  in  1  MEM instruction is in a delay slot.
REQ-008 SHALL have port MEM_VAddr_i  in  32  load/store virtual address.
REQ-009 SHALL have port MEM_Busy_i  in  1  data memory busy; commit forbidden while high.
REQ-010 SHALL have ports CP0Status_i, CP0Cause_i, CP0EPC_i  in  32 each  current CP0 register values.
REQ-011 SHALL have port ExceptType_o  out  9  one-hot to CP0: bit 8 interrupt, bits 7:0 as MEM_ExcFlags_i.
REQ-012 SHALL have ports ExcPCAdd1_o (out 32, captured PC+4), ExcIsDelaySlot_o (out 1), ExcVAddr_o (out 32) to CP0.
REQ-013 SHALL have ports Flush_o (out 1, flush IF..MEM), Redirect_o (out 1), RedirectPC_o (out 32), Stall_o (out 1, freeze pipeline).

Function
REQ-014 SHALL compute IntPending = MEM_Valid_i & Status[0] & ~Status[1] & |(Cause[15:8] & Status[15:8]).
REQ-015 SHALL define Detect = IntPending | (MEM_Valid_i & |MEM_ExcFlags_i).
REQ-016 SHALL select exactly one cause by fixed priority: interrupt > IF addr > RI > syscall > break > eret > overflow > store addr > load addr.
REQ-017 SHALL implement FSM states IDLE, WAIT, COMMIT, HOLD.
REQ-018 IDLE: Detect & ~MEM_Busy_i -> COMMIT; Detect & MEM_Busy_i -> WAIT; else stay.
REQ-019 On leaving IDLE SHALL snapshot selected cause, MEM_PC_i+4, MEM_IsDelaySlot_i, MEM_VAddr_i, and CP0EPC_i.
REQ-020 WAIT: SHALL ignore new flags/interrupts; MEM_Busy_i low -> COMMIT, else stay.
REQ-021 COMMIT: for exactly one cycle SHALL drive ExceptType_o = snapshot one-hot, Exc*_o = snapshot, Flush_o=1, Redirect_o=1; then -> HOLD.
REQ-022 RedirectPC_o in COMMIT SHALL be snapshot EPC for eret, EXC_VECTOR for every other cause.
REQ-023 HOLD: one cycle, all pulses low, Detect ignored (CP0 EXL/EPC settling); -> IDLE.
REQ-024 Stall_o SHALL be 1 combinationally in IDLE when Detect, and in WAIT and COMMIT; 0 otherwise.
REQ-025 Outside COMMIT, ExceptType_o, Flush_o, Redirect_o SHALL be 0; RedirectPC_o, Exc*_o hold last snapshot.
REQ-026 Latency: Detect with Busy low at cycle N -> COMMIT outputs valid in cycle N+1.
REQ-027 Eret SHALL redirect regardless of Status[1]; EXL clearing is CP0's responsibility.
REQ-028 MEM_Valid_i low SHALL suppress detection, including interrupts.
REQ-029 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 0).

Reset
REQ-030 rst high SHALL force IDLE immediately from any state, including mid-WAIT/COMMIT, abandoning snapshot.
REQ-031 During and after reset all outputs SHALL be 0 until the next detection.

Verification
REQ-032 Syscall, PC=0xBFC0_0100, Busy=0 -> next cycle ExceptType_o=0x004, ExcPCAdd1_o=0xBFC0_0104, Flush/Redirect=1, RedirectPC_o=0xBFC0_0380, one cycle only.
REQ-033 Store addr err at VAddr=0x8000_0003 with Busy high 3 cycles -> WAIT 3 cycles, Stall_o=1, then COMMIT with ExceptType_o=0x040, ExcVAddr_o=0x8000_0003.
REQ-034 Status=0x0000_0401, Cause[10]=1, overflow flag set -> ExceptType_o=0x100 (interrupt wins); with Status[1]=1 -> 0x020.
REQ-035 Eret with CP0EPC_i=0xBFC0_0200 -> RedirectPC_o=0xBFC0_0200, ExceptType_o=0x010; flags in HOLD cycle ignored.
REQ-036 rst asserted in WAIT -> outputs 0 asynchronously; after release no COMMIT occurs without new Detect.

Source files
------------

// File: rtl/exception_ctrl.sv
// exception_ctrl: MEM-stage exception and interrupt arbiter. It captures the winning cause,
// waits out a busy data memory, then issues a one-cycle flush/redirect followed by a settle cycle.
module exception_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_Valid_i,
    input  logic [7:0]  MEM_ExcFlags_i,
    input  logic [31:0] MEM_PC_i,
    input  logic        MEM_IsDelaySlot_i,
    input  logic [31:0] MEM_VAddr_i,
    input  logic        MEM_Busy_i,
    input  logic [31:0] CP0Status_i,
    input  logic [31:0] CP0Cause_i,
    input  logic [31:0] CP0EPC_i,
    output logic [8:0]  ExceptType_o,
    output logic [31:0] ExcPCAdd1_o,
    output logic        ExcIsDelaySlot_o,
    output logic [31:0] ExcVAddr_o,
    output logic        Flush_o,
    output logic        Redirect_o,
    output logic [31:0] RedirectPC_o,
    output logic        Stall_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;
    localparam int         ERET_BIT = 4;

    logic [1:0]  state_q, state_d;
    logic [8:0]  cause_q, cause_d;
    logic [31:0] pc4_q, pc4_d;
    logic        ds_q, ds_d;
    logic [31:0] vaddr_q, vaddr_d;
    logic [31:0] redir_q, redir_d;

    logic        int_pending;
    logic        detect;
    logic [7:0]  flags_low;
    logic [8:0]  sel_cause;
    logic        in_commit;

    // Only IE, EXL and the interrupt-mask/pending fields participate in arbitration.
    logic        unused_cp0_bits;
    assign unused_cp0_bits = ^{CP0Status_i[31:16], CP0Status_i[7:2],
                               CP0Cause_i[31:16], CP0Cause_i[7:0]};

    always_comb begin
        int_pending = MEM_Valid_i & CP0Status_i[0] & ~CP0Status_i[1]
                    & (|(CP0Cause_i[15:8] & CP0Status_i[15:8]));
        detect      = int_pending | (MEM_Valid_i & (|MEM_ExcFlags_i));
        // Lowest set flag bit is the highest-priority synchronous cause.
        flags_low   = MEM_ExcFlags_i & (~MEM_ExcFlags_i + 8'd1);
        if (int_pending) begin
            sel_cause = 9'h100;
        end else begin
            sel_cause = {1'b0, flags_low & {8{MEM_Valid_i}}};
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        pc4_d   = pc4_q;
        ds_d    = ds_q;
        vaddr_d = vaddr_q;
        redir_d = redir_q;
        case (state_q)
            S_IDLE: begin
                if (detect) begin
                    state_d = MEM_Busy_i ? S_WAIT : S_COMMIT;
                    cause_d = sel_cause;
                    pc4_d   = MEM_PC_i + 32'd4;
                    ds_d    = MEM_IsDelaySlot_i;
                    vaddr_d = MEM_VAddr_i;
                    redir_d = sel_cause[ERET_BIT] ? CP0EPC_i : EXC_VECTOR;
                end
            end
            S_WAIT: begin
                if (!MEM_Busy_i) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: state_d = S_HOLD;
            default:  state_d = S_IDLE;
        endcase
    end

    // Snapshot is cleared with the FSM so outputs read zero until the next detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cause_q <= '0;
            pc4_q   <= '0;
            ds_q    <= 1'b0;
            vaddr_q <= '0;
            redir_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            pc4_q   <= pc4_d;
            ds_q    <= ds_d;
            vaddr_q <= vaddr_d;
            redir_q <= redir_d;
        end
    end

    always_comb begin
        in_commit        = (state_q == S_COMMIT);
        ExceptType_o     = in_commit ? cause_q : 9'h000;
        Flush_o          = in_commit;
        Redirect_o       = in_commit;
        RedirectPC_o     = redir_q;
        ExcPCAdd1_o      = pc4_q;
        ExcIsDelaySlot_o = ds_q;
        ExcVAddr_o       = vaddr_q;
        Stall_o          = ~rst & (((state_q == S_IDLE) & detect)
                                   | (state_q == S_WAIT) | in_commit);
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: directed scenarios plus randomized traffic against a cycle-level
// reference model built from the arbitration and commit rules.
module tb_exception_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [7:0]  flags;
    logic [31:0] pc, vaddr, status, cause, epc;
    logic        ds, busy;

    logic [8:0]  o_type;
    logic [31:0] o_pc4, o_vaddr, o_rpc;
    logic        o_ds, o_flush, o_redir, o_stall;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: an exception is either waiting on memory, committing this cycle,
    // or settling for one cycle afterwards; none of those means the controller is free.
    bit          m_waiting, m_commit, m_settle;
    logic [8:0]  s_cause;
    logic [31:0] s_pc4, s_vaddr, s_rpc;
    logic        s_ds;

    always #5 clk = ~clk;

    exception_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .MEM_Valid_i       (valid),
        .MEM_ExcFlags_i    (flags),
        .MEM_PC_i          (pc),
        .MEM_IsDelaySlot_i (ds),
        .MEM_VAddr_i       (vaddr),
        .MEM_Busy_i        (busy),
        .CP0Status_i       (status),
        .CP0Cause_i        (cause),
        .CP0EPC_i          (epc),
        .ExceptType_o      (o_type),
        .ExcPCAdd1_o       (o_pc4),
        .ExcIsDelaySlot_o  (o_ds),
        .ExcVAddr_o        (o_vaddr),
        .Flush_o           (o_flush),
        .Redirect_o        (o_redir),
        .RedirectPC_o      (o_rpc),
        .Stall_o           (o_stall)
    );

    function automatic bit m_int();
        return valid && status[0] && !status[1] && ((cause[15:8] & status[15:8]) != 8'h00);
    endfunction

    function automatic bit m_detect();
        return m_int() || (valid && flags != 8'h00);
    endfunction

    function automatic logic [8:0] m_cause();
        if (m_int()) return 9'h100;
        for (int i = 0; i < 8; i++)
            if (valid && flags[i]) return 9'd1 << i;
        return 9'h000;
    endfunction

    task automatic model_clear();
        m_waiting = 0; m_commit = 0; m_settle = 0;
        s_cause = '0; s_pc4 = '0; s_vaddr = '0; s_rpc = '0; s_ds = 1'b0;
    endtask

    task automatic model_step();
        if (rst) begin
            model_clear();
        end else if (m_commit) begin
            m_commit = 0; m_settle = 1;
        end else if (m_settle) begin
            m_settle = 0;
        end else if (m_waiting) begin
            if (!busy) begin m_waiting = 0; m_commit = 1; end
        end else if (m_detect()) begin
            s_cause = m_cause();
            s_pc4   = pc + 32'd4;
            s_ds    = ds;
            s_vaddr = vaddr;
            s_rpc   = (s_cause == 9'h010) ? epc : 32'hBFC0_0380;
            if (busy) m_waiting = 1; else m_commit = 1;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_idle();
        valid = 0; flags = 8'h00; pc = '0; ds = 0; vaddr = '0; busy = 0;
        status = '0; cause = '0; epc = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        valid = 1; flags = 8'h04; pc = 32'hBFC0_0100; #1;
        n_cmp++; if (o_stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %b want 0", o_stall); end
        n_cmp++; if (o_type !== 9'h000) begin n_bad++; $display("FAIL rst_type got %h want 000", o_type); end
        n_cmp++; if (o_flush !== 1'b0 || o_redir !== 1'b0) begin n_bad++; $display("FAIL rst_flush_redir got %b%b want 00", o_flush, o_redir); end
        n_cmp++; if (o_rpc !== 32'h0) begin n_bad++; $display("FAIL rst_rpc got %h want 0", o_rpc); end
        n_cmp++; if (o_pc4 !== 32'h0 || o_vaddr !== 32'h0 || o_ds !== 1'b0) begin n_bad++; $display("FAIL rst_exc got %h %h %b want 0", o_pc4, o_vaddr, o_ds); end
        advance();
        rst = 0; set_idle(); #1;
        n_cmp++; if (o_stall !== 1'b0 || o_type !== 9'h000) begin n_bad++; $display("FAIL rst_release got %b %h want 0 000", o_stall, o_type); end
        advance();
    endtask

    task automatic test_syscall();
        valid = 1; flags = 8'h04; pc = 32'hBFC0_0100; #1;
        n_cmp++; if (o_stall !== 1'b1) begin n_bad++; $display("FAIL sys_detect_stall got %b want 1", o_stall); end
        n_cmp++; if (o_flush !== 1'b0) begin n_bad++; $display("FAIL sys_early_flush got %b want 0", o_flush); end
        advance();
        set_idle(); #1;
        n_cmp++; if (o_type !== 9'h004) begin n_bad++; $display("FAIL sys_type got %h want 004", o_type); end
        n_cmp++; if (o_pc4 !== 32'hBFC0_0104) begin n_bad++; $display("FAIL sys_pc4 got %h want bfc00104", o_pc4); end
        n_cmp++; if (o_flush !== 1'b1 || o_redir !== 1'b1) begin n_bad++; $display("FAIL sys_flush_redir got %b%b want 11", o_flush, o_redir); end
        n_cmp++; if (o_rpc !== 32'hBFC0_0380) begin n_bad++; $display("FAIL sys_rpc got %h want bfc00380", o_rpc); end
        n_cmp++; if (o_stall !== 1'b1) begin n_bad++; $display("FAIL sys_commit_stall got %b want 1", o_stall); end
        advance(); #1;
        n_cmp++; if (o_type !== 9'h000 || o_flush !== 1'b0 || o_redir !== 1'b0) begin n_bad++; $display("FAIL sys_one_cycle got %h %b %b want 000 0 0", o_type, o_flush, o_redir); end
        n_cmp++; if (o_rpc !== 32'hBFC0_0380) begin n_bad++; $display("FAIL sys_rpc_hold got %h want bfc00380", o_rpc); end
        n_cmp++; if (o_stall !== 1'b0) begin n_bad++; $display("FAIL sys_hold_stall got %b want 0", o_stall); end
        advance();
    endtask

    task automatic test_store_busy();
        valid = 1; flags = 8'h40; pc = 32'h8000_1000; vaddr = 32'h8000_0003; busy = 1; #1;
        n_cmp++; if (o_stall !== 1'b1) begin n_bad++; $display("FAIL st_detect_stall got %b want 1", o_stall); end
        advance();
        for (int k = 0; k < 3; k++) begin
            valid = 1; flags = 8'h01; vaddr = 32'h1234_5678; busy = (k < 2); #1;
            n_cmp++; if (o_stall !== 1'b1) begin n_bad++; $display("FAIL st_wait%0d_stall got %b want 1", k, o_stall); end
            n_cmp++; if (o_flush !== 1'b0 || o_type !== 9'h000) begin n_bad++; $display("FAIL st_wait%0d_quiet got %b %h want 0 000", k, o_flush, o_type); end
            advance();
        end
        set_idle(); #1;
        n_cmp++; if (o_type !== 9'h040) begin n_bad++; $display("FAIL st_type got %h want 040", o_type); end
        n_cmp++; if (o_vaddr !== 32'h8000_0003) begin n_bad++; $display("FAIL st_vaddr got %h want 80000003", o_vaddr); end
        n_cmp++; if (o_flush !== 1'b1 || o_pc4 !== 32'h8000_1004) begin n_bad++; $display("FAIL st_commit got %b %h want 1 80001004", o_flush, o_pc4); end
        advance(); advance();
    endtask

    task automatic test_interrupt_priority();
        valid = 1; flags = 8'h20; status = 32'h0000_0401; cause = 32'h0000_0400; #1;
        n_cmp++; if (o_stall !== 1'b1) begin n_bad++; $display("FAIL irq_detect got %b want 1", o_stall); end
        advance();
        set_idle(); #1;
        n_cmp++; if (o_type !== 9'h100) begin n_bad++; $display("FAIL irq_wins got %h want 100", o_type); end
        advance(); advance();
        valid = 1; flags = 8'h20; status = 32'h0000_0403; cause = 32'h0000_0400; #1;
        advance();
        set_idle(); #1;
        n_cmp++; if (o_type !== 9'h020) begin n_bad++; $display("FAIL irq_exl_ovf got %h want 020", o_type); end
        n_cmp++; if (o_rpc !== 32'hBFC0_0380) begin n_bad++; $display("FAIL irq_exl_rpc got %h want bfc00380", o_rpc); end
        advance(); advance();
        valid = 1; flags = 8'h00; status = 32'h0000_0403; cause = 32'h0000_0400; #1;
        n_cmp++; if (o_stall !== 1'b0) begin n_bad++; $display("FAIL irq_masked_exl got %b want 0", o_stall); end
        advance();
        set_idle(); #1;
        n_cmp++; if (o_flush !== 1'b0) begin n_bad++; $display("FAIL irq_masked_flush got %b want 0", o_flush); end
        advance();
    endtask

    task automatic test_eret();
        valid = 1; flags = 8'h10; epc = 32'hBFC0_0200; status = 32'h0000_0002; pc = 32'h8000_0010; #1;
        advance();
        set_idle(); epc = 32'h1234_5678; #1;
        n_cmp++; if (o_type !== 9'h010) begin n_bad++; $display("FAIL eret_type got %h want 010", o_type); end
        n_cmp++; if (o_rpc !== 32'hBFC0_0200) begin n_bad++; $display("FAIL eret_rpc got %h want bfc00200", o_rpc); end
        n_cmp++; if (o_redir !== 1'b1) begin n_bad++; $display("FAIL eret_redir got %b want 1", o_redir); end
        advance();
        valid = 1; flags = 8'h04; #1;
        n_cmp++; if (o_stall !== 1'b0 || o_flush !== 1'b0) begin n_bad++; $display("FAIL eret_hold got %b %b want 0 0", o_stall, o_flush); end
        advance();
        set_idle(); #1;
        n_cmp++; if (o_flush !== 1'b0 || o_type !== 9'h000) begin n_bad++; $display("FAIL eret_hold_ignored got %b %h want 0 000", o_flush, o_type); end
        n_cmp++; if (o_rpc !== 32'hBFC0_0200) begin n_bad++; $display("FAIL eret_rpc_hold got %h want bfc00200", o_rpc); end
        advance();
    endtask

    task automatic test_pc_wrap();
        valid = 1; flags = 8'h02; pc = 32'hFFFF_FFFC; ds = 1; #1;
        advance();
        set_idle(); #1;
        n_cmp++; if (o_pc4 !== 32'h0) begin n_bad++; $display("FAIL wrap_pc4 got %h want 00000000", o_pc4); end
        n_cmp++; if (o_ds !== 1'b1 || o_type !== 9'h002) begin n_bad++; $display("FAIL wrap_ds_type got %b %h want 1 002", o_ds, o_type); end
        advance(); advance();
    endtask

    task automatic test_valid_low();
        valid = 0; flags = 8'hFF; status = 32'h0000_0401; cause = 32'h0000_0400; #1;
        n_cmp++; if (o_stall !== 1'b0) begin n_bad++; $display("FAIL vlow_stall got %b want 0", o_stall); end
        advance(); #1;
        n_cmp++; if (o_flush !== 1'b0 || o_type !== 9'h000) begin n_bad++; $display("FAIL vlow_commit got %b %h want 0 000", o_flush, o_type); end
        set_idle();
        advance();
    endtask

    task automatic test_reset_in_wait();
        valid = 1; flags = 8'h80; pc = 32'h8000_2000; vaddr = 32'h9000_0001; busy = 1; #1;
        advance();
        valid = 0; flags = 8'h00; busy = 1; #1;
        n_cmp++; if (o_stall !== 1'b1 || o_vaddr !== 32'h9000_0001) begin n_bad++; $display("FAIL rw_wait got %b %h want 1 90000001", o_stall, o_vaddr); end
        #2 rst = 1; model_clear(); #1;
        n_cmp++; if (o_stall !== 1'b0) begin n_bad++; $display("FAIL rw_async_stall got %b want 0", o_stall); end
        n_cmp++; if (o_vaddr !== 32'h0 || o_pc4 !== 32'h0 || o_rpc !== 32'h0) begin n_bad++; $display("FAIL rw_async_clear got %h %h %h want 0", o_vaddr, o_pc4, o_rpc); end
        advance();
        rst = 0; busy = 0; #1;
        n_cmp++; if (o_stall !== 1'b0) begin n_bad++; $display("FAIL rw_release_stall got %b want 0", o_stall); end
        for (int k = 0; k < 3; k++) begin
            advance(); #1;
            n_cmp++; if (o_flush !== 1'b0 || o_type !== 9'h000) begin n_bad++; $display("FAIL rw_no_commit%0d got %b %h want 0 000", k, o_flush, o_type); end
        end
        advance();
    endtask

    task automatic test_random();
        bit         e_idle, e_stall;
        logic [8:0] e_type;
        for (int n = 0; n < 600; n++) begin
            rst   = ($urandom_range(0, 79) == 0);
            valid = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0:       flags = 8'h00;
                1:       flags = 8'd1 << $urandom_range(0, 7);
                default: flags = 8'($urandom);
            endcase
            pc     = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            ds     = 1'($urandom);
            vaddr  = $urandom;
            busy   = ($urandom_range(0, 9) < 4);
            status = {16'h0, 8'($urandom), 6'h0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0)};
            cause  = {16'h0, 8'($urandom), 8'h0};
            epc    = $urandom;
            if (rst) model_clear();
            #1;
            e_idle  = !(m_waiting || m_commit || m_settle);
            e_stall = !rst && ((e_idle && m_detect()) || m_waiting || m_commit);
            e_type  = m_commit ? s_cause : 9'h000;
            n_cmp++; if (o_stall !== e_stall) begin n_bad++; $display("FAIL rnd%0d_stall got %b want %b", n, o_stall, e_stall); end
            n_cmp++; if (o_type !== e_type) begin n_bad++; $display("FAIL rnd%0d_type got %h want %h", n, o_type, e_type); end
            n_cmp++; if (o_flush !== m_commit || o_redir !== m_commit) begin n_bad++; $display("FAIL rnd%0d_flush_redir got %b%b want %b", n, o_flush, o_redir, m_commit); end
            n_cmp++; if (o_rpc !== s_rpc) begin n_bad++; $display("FAIL rnd%0d_rpc got %h want %h", n, o_rpc, s_rpc); end
            n_cmp++; if (o_pc4 !== s_pc4) begin n_bad++; $display("FAIL rnd%0d_pc4 got %h want %h", n, o_pc4, s_pc4); end
            n_cmp++; if (o_vaddr !== s_vaddr || o_ds !== s_ds) begin n_bad++; $display("FAIL rnd%0d_vaddr_ds got %h %b want %h %b", n, o_vaddr, o_ds, s_vaddr, s_ds); end
            advance();
        end
        rst = 0; set_idle();
        advance();
    endtask

    initial begin
        rst = 1;
        set_idle();
        model_clear();
        test_reset();
        test_syscall();
        test_store_busy();
        test_interrupt_priority();
        test_eret();
        test_pc_wrap();
        test_valid_low();
        test_reset_in_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
